// File: rtl/rs_scheduler_pkg.sv
// Shared sizing, types and small helpers for the reservation-station scheduler.
package rs_scheduler_pkg;

    localparam int RS_SIZE = 8;
    localparam int IDX_W   = $clog2(RS_SIZE);
    localparam int OCC_W   = IDX_W + 1;

    typedef logic [IDX_W-1:0]   rs_idx_t;
    typedef logic [RS_SIZE-1:0] rs_vec_t;
    typedef logic [OCC_W-1:0]   occ_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic rs_idx_t lowest_idx(input rs_vec_t vec);
        rs_idx_t idx;
        idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) idx = rs_idx_t'(i);
        end
        return idx;
    endfunction

    // One-hot vector with only bit idx set.
    function automatic rs_vec_t idx_onehot(input rs_idx_t idx);
        rs_vec_t one;
        one = rs_vec_t'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/rs_scheduler_if.sv
// Dispatch / RS-array / issue bundle seen by the scheduler.
interface rs_scheduler_if;
    import rs_scheduler_pkg::*;

    logic    squash;
    logic    dispatch_valid;
    rs_vec_t entry_busy;
    rs_vec_t entry_ready;
    logic    fu_ready;
    rs_vec_t alloc_en;
    logic    dispatch_stall;
    logic    issue_valid;
    rs_idx_t issue_idx;
    rs_vec_t clear_en;
    occ_t    occupancy;

    // Pipeline / RS-array side that drives requests and consumes decisions.
    modport master (
        output squash, dispatch_valid, entry_busy, entry_ready, fu_ready,
        input  alloc_en, dispatch_stall, issue_valid, issue_idx, clear_en, occupancy
    );

    // Scheduler side.
    modport slave (
        input  squash, dispatch_valid, entry_busy, entry_ready, fu_ready,
        output alloc_en, dispatch_stall, issue_valid, issue_idx, clear_en, occupancy
    );

endinterface

// File: rtl/rs_scheduler_age_select.sv
// Age matrix plus oldest-ready selection for the reservation station.
module rs_age_select
    import rs_scheduler_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    squash,
    input  rs_vec_t alloc_en,
    input  rs_vec_t entry_busy,
    input  rs_vec_t cand,
    output logic    sel_valid,
    output rs_idx_t sel_idx
);

    // older[i][j] = 1 means entry i was allocated before entry j.
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
    rs_vec_t blocked;
    rs_vec_t qualify;

    // A newly allocated entry is younger than everything currently busy.
    always_ff @(posedge clock) begin
        if (!reset || squash) begin
            older <= '0;
        end else begin
            for (int k = 0; k < RS_SIZE; k++) begin
                if (alloc_en[k]) begin
                    older[k] <= '0;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        if (j != k) older[j][k] <= entry_busy[j];
                    end
                end
            end
        end
    end

    // Pick the candidate no other candidate is older than; fall back to lowest index.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && older[j][i]) blocked[i] = 1'b1;
            end
        end
        qualify   = cand & ~blocked;
        sel_valid = (cand != '0);
        sel_idx   = (qualify != '0) ? lowest_idx(qualify) : lowest_idx(cand);
    end

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: lowest-free allocation and oldest-ready issue.
module rs_scheduler
    import rs_scheduler_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    rs_scheduler_if.slave bus
);

    rs_vec_t free_mask;
    rs_vec_t free_onehot;
    rs_vec_t cand;
    rs_vec_t alloc_int;
    rs_vec_t clear_int;
    logic    sel_valid;
    rs_idx_t sel_idx;
    logic    issue_valid_int;
    logic    dispatch_stall_int;
    rs_idx_t issue_idx_int;
    occ_t    occ_q;

    rs_age_select u_age_select (
        .clock      (clock),
        .reset      (reset),
        .squash     (bus.squash),
        .alloc_en   (alloc_int),
        .entry_busy (bus.entry_busy),
        .cand       (cand),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx)
    );

    // Allocation and issue decisions; everything is forced idle while in reset or squash.
    always_comb begin
        free_mask          = ~bus.entry_busy;
        free_onehot        = free_mask & (~free_mask + rs_vec_t'(1));
        cand               = bus.entry_ready & bus.entry_busy;
        alloc_int          = '0;
        clear_int          = '0;
        dispatch_stall_int = 1'b1;
        issue_valid_int    = 1'b0;
        issue_idx_int      = '0;
        if (reset) begin
            dispatch_stall_int = (free_mask == '0);
            if (bus.dispatch_valid && !bus.squash && free_mask != '0)
                alloc_int = free_onehot;
            issue_valid_int = sel_valid && !bus.squash;
            issue_idx_int   = sel_idx;
            if (issue_valid_int && bus.fu_ready)
                clear_int = idx_onehot(sel_idx);
        end
    end

    assign bus.alloc_en       = alloc_int;
    assign bus.clear_en       = clear_int;
    assign bus.dispatch_stall = dispatch_stall_int;
    assign bus.issue_valid    = issue_valid_int;
    assign bus.issue_idx      = issue_idx_int;
    assign bus.occupancy      = occ_q;

    // Occupancy tracks allocations minus clears; squash empties it.
    always_ff @(posedge clock) begin
        if (!reset || bus.squash) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + occ_t'(|alloc_int) - occ_t'(|clear_int);
        end
    end

    // Occupancy must never overflow past RS_SIZE nor underflow below zero.
    always_ff @(posedge clock) begin
        if (reset && !bus.squash) begin
            assert (occ_q <= occ_t'(RS_SIZE));
            assert (!(occ_q == occ_t'(RS_SIZE) && (|alloc_int) && !(|clear_int)));
            assert (!(occ_q == '0 && (|clear_int) && !(|alloc_int)));
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Scoreboard testbench for rs_scheduler with an independent timestamp-based model.
module tb_rs_scheduler;
    import rs_scheduler_pkg::*;

    typedef struct packed {
        rs_vec_t alloc;
        rs_vec_t clear;
        logic    stall;
        logic    iv;
        rs_idx_t idx;
        occ_t    occ;
    } exp_t;

    logic clock;
    logic reset;
    rs_scheduler_if bus_if ();

    rs_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t    exp_q[$];
    int      check_count;
    int      fail_count;
    rs_vec_t busy_m;
    int      stamp_m[RS_SIZE];
    int      next_stamp;
    int      occ_m;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Pop one expected record and compare every DUT output against it.
    task automatic checkDut(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput({name, ".scoreboard"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput({name, ".alloc_en"},       64'(bus_if.alloc_en),       64'(e.alloc));
        checkOutput({name, ".clear_en"},       64'(bus_if.clear_en),       64'(e.clear));
        checkOutput({name, ".dispatch_stall"}, 64'(bus_if.dispatch_stall), 64'(e.stall));
        checkOutput({name, ".issue_valid"},    64'(bus_if.issue_valid),    64'(e.iv));
        checkOutput({name, ".issue_idx"},      64'(bus_if.issue_idx),      64'(e.idx));
        checkOutput({name, ".occupancy"},      64'(bus_if.occupancy),      64'(e.occ));
    endtask

    // Drive one cycle of stimulus, predict outputs, check them, then advance the model.
    task automatic applyStimulus(input string name, input logic rst_v, input logic sq,
                                 input logic dv, input rs_vec_t rdy, input logic fu);
        exp_t    e;
        rs_vec_t free_v;
        rs_vec_t cand_v;
        int      best;
        reset                 = rst_v;
        bus_if.squash         = sq;
        bus_if.dispatch_valid = dv;
        bus_if.entry_ready    = rdy;
        bus_if.fu_ready       = fu;
        bus_if.entry_busy     = busy_m;

        e       = '0;
        e.occ   = occ_t'(occ_m);
        e.stall = 1'b1;
        if (rst_v) begin
            free_v  = ~busy_m;
            e.stall = (free_v == '0);
            if (dv && !sq) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (free_v[i] && e.alloc == '0) e.alloc[i] = 1'b1;
                end
            end
            cand_v = rdy & busy_m;
            best   = -1;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (cand_v[i] && (best < 0 || stamp_m[i] < stamp_m[best])) best = i;
            end
            if (best >= 0) e.idx = rs_idx_t'(best);
            e.iv = (best >= 0) && !sq;
            if (e.iv && fu) e.clear[best] = 1'b1;
        end
        exp_q.push_back(e);

        #1;
        checkDut(name);

        @(posedge clock);
        #1;
        if (!rst_v || sq) begin
            occ_m  = 0;
            busy_m = '0;
        end else begin
            busy_m = busy_m & ~e.clear;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (e.alloc[i]) begin
                    busy_m[i]  = 1'b1;
                    stamp_m[i] = next_stamp;
                    next_stamp++;
                end
            end
            occ_m = occ_m + ((e.alloc != '0) ? 1 : 0) - ((e.clear != '0) ? 1 : 0);
        end
        @(negedge clock);
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        check_count = 0;
        fail_count  = 0;
        busy_m      = '0;
        occ_m       = 0;
        next_stamp  = 0;
        for (int i = 0; i < RS_SIZE; i++) stamp_m[i] = 0;
        reset                 = 1'b0;
        bus_if.squash         = 1'b0;
        bus_if.dispatch_valid = 1'b0;
        bus_if.entry_ready    = '0;
        bus_if.fu_ready       = 1'b0;
        bus_if.entry_busy     = '0;
        @(posedge clock);
        @(negedge clock);

        applyStimulus("reset0", 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus("reset1", 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus("empty",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        for (int c = 0; c < RS_SIZE; c++)
            applyStimulus($sformatf("fill%0d", c), 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus("full_stall", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

        applyStimulus("full_grant5", 1'b1, 1'b0, 1'b1, 8'h20, 1'b1);
        applyStimulus("realloc5",    1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus("full_again",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int c = 0; c < 3; c++)
            applyStimulus($sformatf("bp_hold%0d", c), 1'b1, 1'b0, 1'b0, 8'h08, 1'b0);
        applyStimulus("bp_grant", 1'b1, 1'b0, 1'b0, 8'h08, 1'b1);
        applyStimulus("bp_after", 1'b1, 1'b0, 1'b0, 8'h08, 1'b1);

        applyStimulus("drain0", 1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        applyStimulus("drain1", 1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        applyStimulus("squash", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        checkOutput("age_matrix_cleared", 64'(dut.u_age_select.older), 64'd0);
        applyStimulus("post_squash", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int c = 0; c < 3; c++)
            applyStimulus($sformatf("of_alloc%0d", c), 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus("oldest_first0", 1'b1, 1'b0, 1'b0, 8'h05, 1'b1);
        applyStimulus("oldest_first1", 1'b1, 1'b0, 1'b0, 8'h05, 1'b1);

        for (int c = 0; c < 400; c++) begin
            applyStimulus($sformatf("rand%0d", c), 1'b1,
                          ($urandom_range(0, 40) == 0),
                          ($urandom_range(0, 2) != 0),
                          rs_vec_t'($urandom()),
                          ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
